// File: rtl/tcrc_gen_pkg.sv
// Shared CRC-15 definitions for the transmit generator and the receive-side CRC cells.
package tcrc_gen_pkg;

   localparam int unsigned CrcWidth = 15;
   localparam logic [CrcWidth-1:0] CrcPoly = 15'h4599;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCalc  = 2'd1,
      StShift = 2'd2,
      StDone  = 2'd3
   } crc_state_e;

   // One serial CRC step; the bit shifted out of the MSB is discarded.
   function automatic logic [CrcWidth-1:0] crc_step(input logic [CrcWidth-1:0] crc,
                                                    input logic                bit_in,
                                                    input logic [CrcWidth-1:0] poly);
      logic nxt;
      nxt = bit_in ^ crc[CrcWidth-1];
      return {crc[CrcWidth-2:0], 1'b0} ^ (nxt ? poly : '0);
   endfunction

endpackage

// File: rtl/tcrc_gen_en_edge_det.sv
// Rising-edge detector for a level bit strobe: one strobe per enable high period.
module en_edge_det (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic strobe
);

   logic flag_q;

   // The flag simply tracks enable, so it is set on the event and cleared when enable drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= enable;
      end
   end

   // A strobe coincident with clear is swallowed: the flag still latches enable.
   assign strobe = enable & ~flag_q & ~clear;

endmodule

// File: rtl/tcrc_gen.sv
// CAN CRC-15 transmit generator: folds frame bits into the CRC, then shifts it out MSB first.
module tcrc_gen
   import tcrc_gen_pkg::*;
#(
   parameter logic [CrcWidth-1:0] POLY = CrcPoly
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                init,
   input  logic                enable,
   input  logic                calc,
   input  logic                data_in,
   output logic                crc_bit,
   output logic [CrcWidth-1:0] crc_reg,
   output logic [3:0]          shift_cnt,
   output logic                crc_done
);

   crc_state_e          state_q, state_d;
   logic [CrcWidth-1:0] crc_q, crc_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                strobe;

   en_edge_det u_edge (
      .clock  (clock),
      .reset  (reset),
      .clear  (init),
      .enable (enable),
      .strobe (strobe)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         crc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      if (init) begin
         state_d = StIdle;
         crc_d   = '0;
         cnt_d   = '0;
      end else if (strobe) begin
         unique case (state_q)
            StIdle, StCalc: begin
               if (calc) begin
                  crc_d   = crc_step(crc_q, data_in, POLY);
                  state_d = StCalc;
               end else begin
                  crc_d   = {crc_q[CrcWidth-2:0], 1'b0};
                  cnt_d   = cnt_q + 4'd1;
                  state_d = StShift;
               end
            end
            StShift: begin
               // calc=1 strobes are ignored once shifting has started.
               if (!calc) begin
                  crc_d = {crc_q[CrcWidth-2:0], 1'b0};
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'(CrcWidth - 1)) begin
                     state_d = StDone;
                  end
               end
            end
            StDone: begin
               // Terminal until init or reset; no counter wrap.
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign crc_reg   = crc_q;
   assign crc_bit   = crc_q[CrcWidth-1];
   assign shift_cnt = cnt_q;
   assign crc_done  = (state_q == StDone);

endmodule

// File: tb/tb_tcrc_gen.sv
// Directed bench for tcrc_gen with a scoreboard queue fed by a bit-level reference model.
module tb_tcrc_gen;

   localparam int MIdle  = 0;
   localparam int MCalc  = 1;
   localparam int MShift = 2;
   localparam int MDone  = 3;

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic        init    = 1'b0;
   logic        enable  = 1'b0;
   logic        calc    = 1'b0;
   logic        data_in = 1'b0;
   logic        crc_bit;
   logic [14:0] crc_reg;
   logic [3:0]  shift_cnt;
   logic        crc_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [14:0] crc;
      logic [3:0]  cnt;
      logic        done;
   } exp_t;

   exp_t        sb[$];
   logic [14:0] m_crc;
   logic [3:0]  m_cnt;
   int          m_st;

   tcrc_gen dut (
      .clock     (clock),
      .reset     (reset),
      .init      (init),
      .enable    (enable),
      .calc      (calc),
      .data_in   (data_in),
      .crc_bit   (crc_bit),
      .crc_reg   (crc_reg),
      .shift_cnt (shift_cnt),
      .crc_done  (crc_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [14:0] model_calc(input logic [14:0] c, input logic d);
      int v;
      v = int'(c) << 1;
      if ((c[14] ^ d) == 1'b1) v = v ^ 'h4599;
      return v[14:0];
   endfunction

   task automatic model_reset();
      m_crc = '0;
      m_cnt = '0;
      m_st  = MIdle;
   endtask

   task automatic model_strobe(input logic c, input logic d);
      if (m_st == MDone) return;
      if (m_st == MShift && c) return;
      if (c) begin
         m_crc = model_calc(m_crc, d);
         m_st  = MCalc;
      end else begin
         m_crc = {m_crc[13:0], 1'b0};
         m_cnt = m_cnt + 4'd1;
         m_st  = (m_cnt == 4'd15) ? MDone : MShift;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.crc  = m_crc;
      e.cnt  = m_cnt;
      e.done = (m_st == MDone);
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, ".crc_reg"}, 32'(crc_reg), 32'(e.crc));
      chk({tag, ".shift_cnt"}, 32'(shift_cnt), 32'(e.cnt));
      chk({tag, ".crc_done"}, 32'(crc_done), 32'(e.done));
      chk({tag, ".crc_bit"}, 32'(crc_bit), 32'(e.crc[14]));
   endtask

   // One enable pulse; calc/data_in are scrambled while enable is low.
   task automatic strobe(input logic c, input logic d, input string tag);
      @(negedge clock);
      calc    = c;
      data_in = d;
      enable  = 1'b1;
      model_strobe(c, d);
      push_exp();
      @(posedge clock);
      #1;
      pop_check(tag);
      @(negedge clock);
      enable  = 1'b0;
      calc    = 1'($urandom);
      data_in = 1'($urandom);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset  = 1'b1;
      enable = 1'b0;
      init   = 1'b0;
      model_reset();
      push_exp();
      #1;
      pop_check("reset");
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [14:0] seq;
      seq = 15'b100010110011001;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      push_exp();
      pop_check("por");
      do_reset();

      // Two CRC updates from zero.
      strobe(1'b1, 1'b1, "calc1");
      chk("calc1.val", 32'(crc_reg), 32'h4599);
      strobe(1'b1, 1'b0, "calc2");
      chk("calc2.val", 32'(crc_reg), 32'h4EAB);

      // Shift out 15'h4599, checking the presented bit before each strobe.
      do_reset();
      strobe(1'b1, 1'b1, "seed");
      for (int i = 0; i < 15; i++) begin
         chk("seq_bit", 32'(crc_bit), 32'(seq[14-i]));
         strobe(1'b0, 1'($urandom), "shift");
      end
      chk("done_flag", 32'(crc_done), 32'd1);

      // Strobes in DONE are ignored.
      for (int i = 0; i < 3; i++) strobe(1'($urandom), 1'($urandom), "done_hold");

      // init with enable high clears and swallows the strobe.
      @(negedge clock);
      init    = 1'b1;
      enable  = 1'b1;
      calc    = 1'b1;
      data_in = 1'b1;
      model_reset();
      push_exp();
      @(posedge clock);
      #1;
      pop_check("init");
      @(negedge clock);
      init = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      push_exp();
      pop_check("init_held");
      @(negedge clock);
      enable = 1'b0;
      strobe(1'b1, 1'b1, "post_init");

      // Level enable held for 10 cycles gives exactly one update.
      do_reset();
      @(negedge clock);
      calc    = 1'b1;
      data_in = 1'b1;
      enable  = 1'b1;
      model_strobe(1'b1, 1'b1);
      repeat (10) @(posedge clock);
      #1;
      push_exp();
      pop_check("level_en");
      @(negedge clock);
      enable = 1'b0;

      // Asynchronous reset after 7 shifts.
      do_reset();
      strobe(1'b1, 1'b1, "ar_seed");
      for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0, "ar_shift");
      #2;
      reset = 1'b1;
      model_reset();
      push_exp();
      #1;
      pop_check("async_rst");
      @(negedge clock);
      reset = 1'b0;
      strobe(1'b1, 1'b1, "ar_after");

      // Shift straight from IDLE, then a calc strobe in SHIFT is ignored.
      do_reset();
      strobe(1'b0, 1'b1, "idle_shift");
      strobe(1'b1, 1'b1, "shift_calc");

      // Random frame folded in and shifted out.
      do_reset();
      for (int i = 0; i < 20; i++) strobe(1'b1, 1'($urandom), "rnd_calc");
      for (int i = 0; i < 15; i++) strobe(1'b0, 1'($urandom), "rnd_shift");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
